// File: rtl/uart_responder.sv
// rtl/uart_responder.sv - strobe-driven UART stand-in: 8N1 transmitter, receiver and RX FIFO
// Answers active-low wrn/rdn strobes on a shared 16-bit bus and reports tbre/tsre/data_ready.
module uart_responder #(
  parameter int CLKS_PER_BIT = 96,
  parameter int RX_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrn_i,
  input  logic        rdn_i,
  inout  wire  [15:0] data_io,
  output logic        data_ready_o,
  output logic        tbre_o,
  output logic        tsre_o,
  output logic        txd_o,
  input  logic        rxd_i
);
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int PW   = $clog2(RX_DEPTH);
  localparam int CNTW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic wrn_q, rdn_q;
  logic wr_accept, pop_evt;

  state_t        tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_shift;
  logic [7:0]    hold;
  logic          tx_last;

  logic [1:0]    rx_sync;
  logic          rx_s;
  state_t        rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shift;
  logic          rx_last;
  logic          rx_push;

  logic [7:0]      mem [RX_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] rx_count;
  logic            fifo_empty, fifo_full;
  logic            do_push, do_pop;
  logic [7:0]      rd_byte;
  logic            unused_bus_hi;

  assign unused_bus_hi = ^data_io[15:8];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrn_q <= 1'b1;
      rdn_q <= 1'b1;
    end else begin
      wrn_q <= wrn_i;
      rdn_q <= rdn_i;
    end
  end

  assign wr_accept = !wrn_i && wrn_q;
  assign pop_evt   = rdn_i && !rdn_q;

  // A simultaneous wrn/rdn low is a write, so the bus is never driven then.
  assign data_io = (!rdn_i && wrn_i) ? {8'h00, rd_byte} : 16'bz;

  assign tx_last = (tx_cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      hold     <= '0;
      tbre_o   <= 1'b1;
      tsre_o   <= 1'b1;
      txd_o    <= 1'b1;
    end else begin
      if (wr_accept && tbre_o) begin
        hold   <= data_io[7:0];
        tbre_o <= 1'b0;
      end
      case (tx_state)
        S_IDLE: begin
          if (!tbre_o) begin
            tx_shift <= hold;
            tbre_o   <= 1'b1;
            tsre_o   <= 1'b0;
            txd_o    <= 1'b0;
            tx_cnt   <= '0;
            tx_state <= S_START;
          end
        end
        S_START: begin
          if (tx_last) begin
            tx_cnt   <= '0;
            tx_idx   <= '0;
            txd_o    <= tx_shift[0];
            tx_state <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (tx_last) begin
            tx_cnt   <= '0;
            tx_shift <= {1'b0, tx_shift[7:1]};
            if (tx_idx == 3'd7) begin
              txd_o    <= 1'b1;
              tx_state <= S_STOP;
            end else begin
              tx_idx <= tx_idx + 3'd1;
              txd_o  <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (tx_last) begin
            tx_cnt <= '0;
            // Reload straight into a new start bit so queued bytes leave gap-free.
            if (!tbre_o) begin
              tx_shift <= hold;
              tbre_o   <= 1'b1;
              txd_o    <= 1'b0;
              tx_state <= S_START;
            end else begin
              tsre_o   <= 1'b1;
              tx_state <= S_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  assign rx_s    = rx_sync[1];
  assign rx_last = (rx_cnt == CW'(CLKS_PER_BIT - 1));
  assign rx_push = (rx_state == S_STOP) && rx_last && rx_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync  <= 2'b11;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      rx_sync <= {rx_sync[0], rxd_i};
      case (rx_state)
        S_IDLE: begin
          if (!rx_s) begin
            rx_cnt   <= '0;
            rx_state <= S_START;
          end
        end
        S_START: begin
          // Mid-bit recheck rejects glitches; later samples stay mid-bit.
          if (rx_cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
            rx_cnt <= '0;
            rx_idx <= '0;
            rx_state <= rx_s ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (rx_last) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s, rx_shift[7:1]};
            if (rx_idx == 3'd7) begin
              rx_state <= S_STOP;
            end else begin
              rx_idx <= rx_idx + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (rx_last) begin
            rx_cnt   <= '0;
            rx_state <= S_IDLE;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  assign fifo_empty   = (rx_count == '0);
  assign fifo_full    = (rx_count == CNTW'(RX_DEPTH));
  assign do_pop       = pop_evt && !fifo_empty;
  assign do_push      = rx_push && (!fifo_full || do_pop);
  assign rd_byte      = fifo_empty ? 8'h00 : mem[rd_ptr];
  assign data_ready_o = !fifo_empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= rx_shift;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_count <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   rx_count <= rx_count + CNTW'(1);
        2'b01:   rx_count <= rx_count - CNTW'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_responder.sv
// tb/tb_uart_responder.sv - self-checking bench for uart_responder
module tb_uart_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wrn = 1'b1;
  logic        rdn = 1'b1;
  logic        rxd = 1'b1;
  logic        tb_en = 1'b0;
  logic [15:0] tb_val = 16'h0000;
  wire  [15:0] bus;
  logic        data_ready, tbre, tsre, txd;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rst_cnt = 0;

  typedef struct {
    logic [7:0] b;
    logic       stop;
    int         start;
  } frame_t;

  frame_t     tx_got[$];
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];

  assign bus = tb_en ? tb_val : 16'hzzzz;
  pullup (bus);

  uart_responder #(.CLKS_PER_BIT(4), .RX_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .wrn_i        (wrn),
    .rdn_i        (rdn),
    .data_io      (bus),
    .data_ready_o (data_ready),
    .tbre_o       (tbre),
    .tsre_o       (tsre),
    .txd_o        (txd),
    .rxd_i        (rxd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge rst) rst_cnt = rst_cnt + 1;

  // Serial-line monitor: decodes frames mid-bit, drops any frame cut by reset.
  initial begin : tx_mon
    frame_t f;
    int     rc;
    logic   ok;
    forever begin
      @(negedge clk);
      if (rst && txd === 1'b0) begin
        rc = rst_cnt;
        f.start = cyc;
        ok = 1'b1;
        repeat (2) @(negedge clk);
        if (txd !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          f.b[i] = txd;
        end
        repeat (4) @(negedge clk);
        f.stop = txd;
        if (ok && rc == rst_cnt) tx_got.push_back(f);
      end
    end
  end

  task automatic do_write(input logic [15:0] d);
    @(posedge clk); #1;
    tb_val = d;
    tb_en  = 1'b1;
    wrn    = 1'b0;
    @(posedge clk); #1;
    wrn   = 1'b1;
    tb_en = 1'b0;
  endtask

  task automatic do_read(output logic [15:0] v);
    @(posedge clk); #1;
    rdn = 1'b0;
    @(posedge clk); #1;
    v   = bus;
    rdn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input int pop_at,
                         output logic [15:0] popv);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    popv = 16'h0000;
    @(posedge clk);
    for (int k = 0; k < 46; k++) begin
      if (k > 0) @(posedge clk);
      #1;
      rxd = (k < 40) ? fr[k/4] : 1'b1;
      if (k == pop_at - 2) rdn = 1'b0;
      if (k == pop_at - 1) begin
        popv = bus;
        rdn  = 1'b1;
      end
    end
    if (stop && rx_exp.size() < 4) rx_exp.push_back(b);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL rst_txd got=%b want=1", txd); end
    total++; if (tbre !== 1'b1) begin bad++; $display("FAIL rst_tbre got=%b want=1", tbre); end
    total++; if (tsre !== 1'b1) begin bad++; $display("FAIL rst_tsre got=%b want=1", tsre); end
    total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL rst_dr got=%b want=0", data_ready); end
    total++; if (bus !== 16'hFFFF) begin bad++; $display("FAIL rst_bus got=%h want=FFFF(undriven)", bus); end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (txd !== 1'b1 || tbre !== 1'b1 || tsre !== 1'b1) begin
      bad++; $display("FAIL post_rst got txd=%b tbre=%b tsre=%b want 1/1/1", txd, tbre, tsre);
    end
  endtask

  task automatic test_single_write();
    int     acc, t;
    frame_t f;
    logic [7:0] e;
    do_write(16'hFF5A);
    acc = cyc;
    tx_exp.push_back(8'h5A);
    total++; if (tbre !== 1'b0) begin bad++; $display("FAIL sw_tbre_n got=%b want=0", tbre); end
    @(posedge clk); #1;
    total++; if ({tbre, tsre, txd} !== 3'b100) begin
      bad++; $display("FAIL sw_n1 got tbre/tsre/txd=%b want=100", {tbre, tsre, txd});
    end
    repeat (39) @(posedge clk);
    #1;
    total++; if (tsre !== 1'b0 || txd !== 1'b1) begin
      bad++; $display("FAIL sw_n40 got tsre=%b txd=%b want 0/1", tsre, txd);
    end
    @(posedge clk); #1;
    total++; if (tsre !== 1'b1) begin bad++; $display("FAIL sw_tsre_n41 got=%b want=1", tsre); end
    t = 0;
    while (tx_got.size() < 1 && t < 100) begin @(posedge clk); t++; end
    total++;
    if (tx_got.size() < 1) begin
      bad++; $display("FAIL sw_frame got=none want=frame");
    end else begin
      f = tx_got.pop_front();
      e = tx_exp.pop_front();
      if (f.b !== e || f.stop !== 1'b1 || f.start != acc + 1) begin
        bad++;
        $display("FAIL sw_frame got=%h stop=%b start=%0d want=%h stop=1 start=%0d",
                 f.b, f.stop, f.start, e, acc + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int     acc, t;
    frame_t f1, f2;
    logic [7:0] e1, e2;
    do_write(16'h0001);
    acc = cyc;
    tx_exp.push_back(8'h01);
    @(posedge clk); #1;
    total++; if (tbre !== 1'b1) begin bad++; $display("FAIL b2b_tbre got=%b want=1", tbre); end
    do_write(16'h0080);
    tx_exp.push_back(8'h80);
    total++; if (tbre !== 1'b0) begin bad++; $display("FAIL b2b_full got=%b want=0", tbre); end
    do_write(16'h00EE);
    t = 0;
    while (tx_got.size() < 2 && t < 200) begin @(posedge clk); t++; end
    total++;
    if (tx_got.size() < 2) begin
      bad++; $display("FAIL b2b_frames got=%0d want=2", tx_got.size());
    end else begin
      f1 = tx_got.pop_front();
      f2 = tx_got.pop_front();
      e1 = tx_exp.pop_front();
      e2 = tx_exp.pop_front();
      if (f1.b !== e1 || f2.b !== e2 || f1.stop !== 1'b1 || f2.stop !== 1'b1) begin
        bad++; $display("FAIL b2b_data got=%h,%h want=%h,%h", f1.b, f2.b, e1, e2);
      end
      total++;
      if (f1.start != acc + 1 || f2.start - f1.start != 40) begin
        bad++; $display("FAIL b2b_gap got start1=%0d gap=%0d want start1=%0d gap=40",
                        f1.start, f2.start - f1.start, acc + 1);
      end
    end
    repeat (60) @(posedge clk);
    #1;
    total++; if (tx_got.size() != 0 || tsre !== 1'b1) begin
      bad++; $display("FAIL b2b_ignored got extra=%0d tsre=%b want 0/1", tx_got.size(), tsre);
    end
    tx_got.delete();
  endtask

  task automatic test_receive();
    logic [15:0] v, pv;
    logic [15:0] e;
    send_rx(8'hC3, 1'b1, -10, pv);
    send_rx(8'h3C, 1'b1, -10, pv);
    total++; if (data_ready !== 1'b1) begin bad++; $display("FAIL rx_dr got=%b want=1", data_ready); end
    for (int i = 0; i < 3; i++) begin
      e = (rx_exp.size() > 0) ? {8'h00, rx_exp.pop_front()} : 16'h0000;
      do_read(v);
      total++; if (v !== e) begin bad++; $display("FAIL rx_read%0d got=%h want=%h", i, v, e); end
      if (i == 1) begin
        total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL rx_dr_empty got=%b want=0", data_ready); end
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] v, pv;
    logic [15:0] e;
    for (int i = 0; i < 5; i++) send_rx(8'h10 + 8'(i), 1'b1, -10, pv);
    for (int i = 0; i < 5; i++) begin
      e = (rx_exp.size() > 0) ? {8'h00, rx_exp.pop_front()} : 16'h0000;
      do_read(v);
      total++; if (v !== e) begin bad++; $display("FAIL ovf_read%0d got=%h want=%h", i, v, e); end
    end
  endtask

  task automatic test_errors();
    logic [15:0] v, pv;
    send_rx(8'h55, 1'b0, -10, pv);
    @(posedge clk); #1;
    rxd = 1'b0;
    @(posedge clk); #1;
    rxd = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL err_dr got=%b want=0", data_ready); end
    do_read(v);
    total++; if (v !== 16'h0000) begin bad++; $display("FAIL err_read got=%h want=0000", v); end
  endtask

  task automatic test_simul_push_pop();
    logic [15:0] v, pv;
    logic [15:0] e;
    for (int i = 0; i < 4; i++) send_rx(8'hA0 + 8'(i), 1'b1, -10, pv);
    e = {8'h00, rx_exp.pop_front()};
    send_rx(8'hA4, 1'b1, 41, pv);
    total++; if (pv !== e) begin bad++; $display("FAIL sim_pop got=%h want=%h", pv, e); end
    for (int i = 0; i < 5; i++) begin
      e = (rx_exp.size() > 0) ? {8'h00, rx_exp.pop_front()} : 16'h0000;
      do_read(v);
      total++; if (v !== e) begin bad++; $display("FAIL sim_read%0d got=%h want=%h", i, v, e); end
    end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] pv;
    send_rx(8'h99, 1'b1, -10, pv);
    do_write(16'h0077);
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    total++; if ({txd, tbre, tsre, data_ready} !== 4'b1110) begin
      bad++; $display("FAIL mid_rst got txd/tbre/tsre/dr=%b want=1110", {txd, tbre, tsre, data_ready});
    end
    total++; if (bus !== 16'hFFFF) begin bad++; $display("FAIL mid_rst_bus got=%h want=FFFF", bus); end
    rx_exp.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    total++; if (tx_got.size() != 0 || txd !== 1'b1 || tsre !== 1'b1 || data_ready !== 1'b0) begin
      bad++; $display("FAIL mid_after got frames=%0d txd=%b tsre=%b dr=%b want 0/1/1/0",
                      tx_got.size(), txd, tsre, data_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_receive();
    test_overflow();
    test_errors();
    test_simul_push_pop();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
